mips_test_sequencer: RTL and testbench

- Synthesizable boot-and-check sequencer for the pipelined MIPS32 core; replaces hierarchical testbench pokes with a real port-driven flow.
- Loads (addr, data) pairs into unified MEM, optionally seeds the register file, releases the core from PC=0, and waits for HALTED or a timeout.
- Then reads back expected (addr, value) pairs and reports pass/fail.
- Sits between a host/bench stream source and the core's memory-init port and run-control.

---
 rtl/mips_seq_pkg.sv | 23 ++
 rtl/mips_seq_timer.sv | 30 +++
 rtl/mips_test_sequencer.sv | 170 +++++++++++++++++
 tb/tb_mips_test_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_seq_pkg.sv
// Shared types and constants for the MIPS32 boot-and-check sequencer.
package mips_seq_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 10;
    localparam int TIMEOUT_DEF  = 1024;
    localparam int CNT_W_DEF    = 8;
    localparam int NUM_REGS_DEF = 32;

    localparam logic [5:0] HLT_OPCODE = 6'h3f;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_REGINIT,
        ST_CLR,
        ST_RUN,
        ST_CHK_RD,
        ST_CHK_CMP,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/mips_seq_timer.sv
// RUN-phase watchdog: loaded with TIMEOUT-1, counts down while enabled,
// and flags expiry during the enabled cycle in which it reaches zero.
module mips_seq_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk1,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int T_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [T_W-1:0] LOAD_VAL = T_W'(TIMEOUT - 1);

    logic [T_W-1:0] count;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expire = en && (count == '0);

endmodule

// File: rtl/mips_test_sequencer.sv
// Boot-and-check sequencer: loads MEM, optionally seeds registers
// (MIPS_SEQ_REGINIT_EN), runs the core from PC=0, then verifies expected words.
module mips_test_sequencer
    import mips_seq_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic              chk_valid,
    output logic              chk_ready,
    input  logic [ADDR_W-1:0] chk_addr,
    input  logic [DATA_W-1:0] chk_data,
    input  logic              chk_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              reg_we,
    output logic [4:0]        reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              core_hold,
    output logic              core_clr,
    input  logic              core_halted,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [ADDR_W-1:0] fail_addr
);

    seq_state_t        state;
    logic [DATA_W-1:0] exp_data;
    logic [ADDR_W-1:0] exp_addr;
    logic              exp_last;
    logic              timer_expire;
    logic              mismatch;

`ifdef MIPS_SEQ_REGINIT_EN
    localparam seq_state_t AFTER_LOAD = ST_REGINIT;
    localparam logic [4:0] REG_LAST   = 5'(NUM_REGS - 1);
    logic [4:0] reg_idx;

    assign reg_we    = (state == ST_REGINIT);
    assign reg_addr  = reg_idx;
    assign reg_wdata = DATA_W'(reg_idx);
`else
    localparam seq_state_t AFTER_LOAD = ST_CLR;

    assign reg_we    = 1'b0;
    assign reg_addr  = '0;
    assign reg_wdata = '0;
`endif

    // The sequencer owns the MEM port everywhere except RUN.
    assign ld_ready  = (state == ST_LOAD);
    assign chk_ready = (state == ST_CHK_RD);
    assign core_hold = (state != ST_RUN);
    assign core_clr  = (state == ST_CLR);
    assign mem_we    = ld_ready && ld_valid;
    assign mem_wdata = ld_ready ? ld_data : '0;
    assign mem_addr  = ld_ready  ? ld_addr  :
                       chk_ready ? chk_addr : '0;
    assign mismatch  = (mem_rdata != exp_data);

    mips_seq_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk1   (clk1),
        .rst_n  (rst_n),
        .load   (state == ST_CLR),
        .en     (state == ST_RUN),
        .expire (timer_expire)
    );

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            fail_cnt  <= '0;
            fail_addr <= '0;
`ifdef MIPS_SEQ_REGINIT_EN
            reg_idx   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        timeout   <= 1'b0;
                        fail_cnt  <= '0;
                        fail_addr <= '0;
                        busy      <= 1'b1;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
`ifdef MIPS_SEQ_REGINIT_EN
                    reg_idx <= '0;
`endif
                    if (ld_valid && ld_last) state <= AFTER_LOAD;
                end
                ST_REGINIT: begin
`ifdef MIPS_SEQ_REGINIT_EN
                    if (reg_idx == REG_LAST) state <= ST_CLR;
                    else reg_idx <= reg_idx + 1'b1;
`else
                    state <= ST_CLR;
`endif
                end
                ST_CLR: state <= ST_RUN;
                ST_RUN: begin
                    // A halt seen on the final budget cycle still counts as a halt.
                    if (core_halted) begin
                        state <= ST_CHK_RD;
                    end else if (timer_expire) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                        state   <= ST_DONE;
                    end
                end
                ST_CHK_RD: begin
                    if (chk_valid) state <= ST_CHK_CMP;
                end
                ST_CHK_CMP: begin
                    if (mismatch) begin
                        if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
                        if (fail_cnt == '0) fail_addr <= exp_addr;
                    end
                    if (exp_last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= !mismatch && (fail_cnt == '0);
                        state <= ST_DONE;
                    end else begin
                        state <= ST_CHK_RD;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk1) begin
        if (chk_ready && chk_valid) begin
            exp_data <= chk_data;
            exp_addr <= chk_addr;
            exp_last <= chk_last;
        end
    end

endmodule

// File: tb/tb_mips_test_sequencer.sv
// Bench for mips_test_sequencer: behavioural MEM plus a stand-in core that
// recognises the test program's HLT word and applies its net store.
module tb_mips_test_sequencer;
    import mips_seq_pkg::*;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 10;
    localparam int TIMEOUT  = 200;
    localparam int CNT_W    = 8;
    localparam int NUM_REGS = 32;
`ifdef MIPS_SEQ_REGINIT_EN
    localparam int EXP_REGS = NUM_REGS;
`else
    localparam int EXP_REGS = 0;
`endif

    localparam logic [31:0] PROG [8] = '{
        32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
        32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000
    };
    localparam logic [31:0] OR_WORD = 32'h0c631800;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    typedef struct packed {
        logic              pass;
        logic              timeout;
        logic [CNT_W-1:0]  cnt;
        logic [ADDR_W-1:0] addr;
    } res_t;

    logic              clk1 = 1'b0;
    logic              rst_n, start;
    logic              ld_valid, ld_ready, ld_last;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              chk_valid, chk_ready, chk_last;
    logic [ADDR_W-1:0] chk_addr;
    logic [DATA_W-1:0] chk_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              reg_we;
    logic [4:0]        reg_addr;
    logic [DATA_W-1:0] reg_wdata;
    logic              core_hold, core_clr, core_halted;
    logic              busy, done, pass, timeout;
    logic [CNT_W-1:0]  fail_cnt;
    logic [ADDR_W-1:0] fail_addr;

    mips_test_sequencer #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .TIMEOUT  (TIMEOUT),
        .CNT_W    (CNT_W),
        .NUM_REGS (NUM_REGS)
    ) dut (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .start       (start),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .chk_valid   (chk_valid),
        .chk_ready   (chk_ready),
        .chk_addr    (chk_addr),
        .chk_data    (chk_data),
        .chk_last    (chk_last),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .reg_we      (reg_we),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .core_hold   (core_hold),
        .core_clr    (core_clr),
        .core_halted (core_halted),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .fail_cnt    (fail_cnt),
        .fail_addr   (fail_addr)
    );

    always #5 clk1 = ~clk1;

    // MEM with one-cycle read latency and the stand-in core.
    logic [DATA_W-1:0] mem [0:1023];
    logic [DATA_W-1:0] rdata_q;
    logic              halted;
    int                run_cnt;

    assign mem_rdata   = rdata_q;
    assign core_halted = halted;

    always @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            halted  <= 1'b0;
            run_cnt <= 0;
        end else begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            rdata_q <= mem[mem_addr];
            if (core_clr) begin
                halted  <= 1'b0;
                run_cnt <= 0;
            end else if (!core_hold && !halted) begin
                run_cnt <= run_cnt + 1;
                if (run_cnt == 10 && mem[7][31:26] == HLT_OPCODE) begin
                    mem[121] <= mem[120] + 32'd45;
                    halted   <= 1'b1;
                end
            end
        end
    end

    int   checks = 0;
    int   errors = 0;
    wr_t  exp_wr [$];
    res_t exp_res[$];
    int   we_cnt = 0, clr_cnt = 0, run_cycles = 0, chk_rdy_cycles = 0, reg_cnt = 0;
    logic done_q = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic monitor_step();
        wr_t  w;
        res_t r;
        if (rst_n) begin
            if (mem_we) begin
                we_cnt++;
                if (exp_wr.size() == 0) begin
                    check("mem_we_unexpected", 1, 0);
                end else begin
                    w = exp_wr.pop_front();
                    check("mem_addr", 64'(mem_addr), 64'(w.addr));
                    check("mem_wdata", 64'(mem_wdata), 64'(w.data));
                end
            end
            if (core_clr) clr_cnt++;
            if (!core_hold) run_cycles++;
            if (chk_ready) chk_rdy_cycles++;
            if (reg_we) begin
                reg_cnt++;
                check("reg_wdata", 64'(reg_wdata), 64'(reg_addr));
            end
            if (done && !done_q) begin
                if (exp_res.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    r = exp_res.pop_front();
                    check("pass", 64'(pass), 64'(r.pass));
                    check("timeout", 64'(timeout), 64'(r.timeout));
                    check("fail_cnt", 64'(fail_cnt), 64'(r.cnt));
                    check("fail_addr", 64'(fail_addr), 64'(r.addr));
                end
            end
        end
        done_q = done;
    endtask

    task automatic do_start(input logic p, input logic t, input logic [CNT_W-1:0] c,
                            input logic [ADDR_W-1:0] a);
        res_t r;
        r.pass = p; r.timeout = t; r.cnt = c; r.addr = a;
        exp_res.push_back(r);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 64'(busy), 1);
        check("done_cleared", 64'(done), 0);
    endtask

    task automatic load_pair(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             input logic last, input logic gap);
        wr_t w;
        int  n = 0;
        w.addr = a; w.data = d;
        exp_wr.push_back(w);
        ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_last = last;
        while (!ld_ready && n < 100) begin tick(); n++; end
        if (!ld_ready) check("ld_ready_wait", 0, 1);
        tick();
        ld_last = 1'b0;
        if (gap || last) ld_valid = 1'b0;
        if (gap) tick();
    endtask

    task automatic chk_pair(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input logic last);
        int n = 0;
        chk_valid = 1'b1; chk_addr = a; chk_data = d; chk_last = last;
        while (!chk_ready && n < 400) begin tick(); n++; end
        if (!chk_ready) check("chk_ready_wait", 0, 1);
        tick();
        chk_valid = 1'b0; chk_last = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 1000) begin tick(); n++; end
        if (!done) check("done_wait", 0, 1);
        tick();
    endtask

    task automatic load_program();
        for (int i = 0; i < 8; i++) load_pair(ADDR_W'(i), PROG[i], 1'b0, 1'b0);
        load_pair(10'd120, 32'd85, 1'b1, 1'b0);
    endtask

    int snap_run, snap_chk, snap_clr, snap_we, snap_reg;

    initial begin
        rst_n = 1'b0; start = 1'b0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0;
        chk_valid = 1'b0; chk_addr = '0; chk_data = '0; chk_last = 1'b0;
        fork
            forever begin @(negedge clk1); monitor_step(); end
            begin
                #2000000;
                $display("FAIL watchdog expired");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) tick();
        check("rst_core_hold", 64'(core_hold), 1);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_pass", 64'(pass), 0);
        check("rst_timeout", 64'(timeout), 0);
        check("rst_fail_cnt", 64'(fail_cnt), 0);
        check("rst_fail_addr", 64'(fail_addr), 0);
        check("rst_readies", 64'({ld_ready, chk_ready, mem_we, core_clr}), 0);
        rst_n = 1'b1;
        tick();

        // Passing program
        snap_reg = reg_cnt; snap_clr = clr_cnt;
        do_start(1'b1, 1'b0, '0, '0);
        load_program();
        chk_pair(10'd121, 32'd130, 1'b1);
        wait_done();
        check("t1_reg_writes", 64'(reg_cnt - snap_reg), 64'(EXP_REGS));
        check("t1_clr_pulses", 64'(clr_cnt - snap_clr), 1);
        repeat (4) tick();
        check("t1_done_held", 64'({done, pass, busy}), 64'(3'b110));

        // One mismatch among two checks
        do_start(1'b0, 1'b0, 8'd1, 10'd121);
        load_program();
        chk_pair(10'd121, 32'd131, 1'b0);
        chk_pair(10'd120, 32'd85, 1'b1);
        wait_done();

        // No HLT: abort on timeout without consuming the check stream
        snap_run = run_cycles; snap_chk = chk_rdy_cycles;
        do_start(1'b0, 1'b1, '0, '0);
        for (int i = 0; i < 8; i++) load_pair(ADDR_W'(i), OR_WORD, (i == 7), 1'b0);
        wait_done();
        check("t3_run_cycles", 64'(run_cycles - snap_run), 64'(TIMEOUT));
        check("t3_chk_ready", 64'(chk_rdy_cycles - snap_chk), 0);

        // Stalled load stream with a repeated address
        snap_we = we_cnt; snap_clr = clr_cnt;
        do_start(1'b1, 1'b0, '0, '0);
        load_pair(10'd200, 32'h1111_0000, 1'b0, 1'b1);
        load_pair(10'd201, 32'h2222_0000, 1'b0, 1'b1);
        load_pair(10'd200, 32'h3333_0000, 1'b0, 1'b1);
        load_pair(10'd7, PROG[7], 1'b1, 1'b1);
        chk_pair(10'd200, 32'h3333_0000, 1'b0);
        chk_pair(10'd201, 32'h2222_0000, 1'b1);
        wait_done();
        check("t4_we_pulses", 64'(we_cnt - snap_we), 4);
        check("t4_clr_pulses", 64'(clr_cnt - snap_clr), 1);

        // Reset during RUN, then a clean replay
        do_start(1'b1, 1'b0, '0, '0);
        load_program();
        begin
            int n = 0;
            while (core_hold && n < 200) begin tick(); n++; end
            if (core_hold) check("t5_run_wait", 0, 1);
        end
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("t5_rst_hold", 64'(core_hold), 1);
        check("t5_rst_busy", 64'(busy), 0);
        check("t5_rst_done", 64'(done), 0);
        exp_res.delete();
        tick();
        rst_n = 1'b1;
        tick();
        do_start(1'b1, 1'b0, '0, '0);
        load_program();
        chk_pair(10'd121, 32'd130, 1'b1);
        wait_done();

        // Saturating mismatch counter; start pulse while checking is ignored
        do_start(1'b0, 1'b0, 8'd255, 10'd500);
        for (int j = 0; j < 50; j++) load_pair(ADDR_W'(500 + j), DATA_W'(j), 1'b0, 1'b0);
        load_pair(10'd7, PROG[7], 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            if (i == 1) start = 1'b1;
            chk_pair(ADDR_W'(500 + (i % 50)), DATA_W'((i % 50) + 1), (i == 299));
            if (i == 1) begin
                start = 1'b0;
                check("t6_start_ignored", 64'({busy, done}), 64'(2'b10));
            end
        end
        wait_done();
        check("t6_results_pending", 64'(exp_res.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
